// File: rtl/systolic_skew_feeder.sv
// Skew feeder for the MAC systolic array: lane i of each operand bus is delayed
// by i cycles so A and B slices meet on the diagonal, then the chains drain with zeros.
module systolic_skew_feeder #(
  parameter int ARR_SIZE      = 4,
  parameter int HORIZONTAL_BW = 16,
  parameter int CNT_W         = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CNT_W-1:0]                  k_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] a_vec,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] b_vec,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] vertical_input,
  output logic                              busy,
  output logic                              done
);

  localparam int BW = HORIZONTAL_BW;
  localparam int DW = (ARR_SIZE > 2) ? $clog2(ARR_SIZE - 1) : 1;
  localparam bit HAS_DRAIN = (ARR_SIZE > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] k_len_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             accept;
  logic             last_beat;
  logic             drain_last;

  assign accept     = in_valid && (state == FEED);
  assign last_beat  = accept && (beat_cnt == (k_len_q - 1'b1));
  assign drain_last = (drain_cnt == DW'(HAS_DRAIN ? ARR_SIZE - 2 : 0));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (k_len != '0) ? FEED : DONE;
      FEED:    if (last_beat) state_next = HAS_DRAIN ? DRAIN : DONE;
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      FEED:    begin in_ready = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // k_len is captured only at a start taken in IDLE; later edits do not reach the tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        k_len_q  <= k_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  // Lane i owns i+1 stages; the last stage drives the array bus directly.
  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    logic [BW-1:0] a_chain [i+1];
    logic [BW-1:0] b_chain [i+1];

    // NOTE: the skew stages are reset like any other register so a mid-tile
    // reset discards partial slices instead of leaking them into the array.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= i; j++) begin
          a_chain[j] <= '0;
          b_chain[j] <= '0;
        end
      end else begin
        a_chain[0] <= accept ? a_vec[i*BW +: BW] : '0;
        b_chain[0] <= accept ? b_vec[i*BW +: BW] : '0;
        for (int j = 1; j <= i; j++) begin
          a_chain[j] <= a_chain[j-1];
          b_chain[j] <= b_chain[j-1];
        end
      end
    end

    assign horizontal_input[i*BW +: BW] = a_chain[i];
    assign vertical_input[i*BW +: BW]   = b_chain[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus pushes expected lane
// values and done cycles; a negedge monitor pops and compares them.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int CW = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [CW-1:0]     k_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BW*N-1:0]   a_vec = '0;
  logic [BW*N-1:0]   b_vec = '0;
  logic [BW*N-1:0]   horizontal_input;
  logic [BW*N-1:0]   vertical_input;
  logic              busy;
  logic              done;

  systolic_skew_feeder #(.ARR_SIZE(N), .HORIZONTAL_BW(BW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .k_len            (k_len),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a_vec            (a_vec),
    .b_vec            (b_vec),
    .horizontal_input (horizontal_input),
    .vertical_input   (vertical_input),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } exp_t;

  exp_t lane_q [N][$];
  int   done_q [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_left = 0;
  int   busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every cycle each lane either matches its queued value or is zero.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cycles++;
      for (int i = 0; i < N; i++) begin
        logic [BW-1:0] ga, gb;
        ga = horizontal_input[i*BW +: BW];
        gb = vertical_input[i*BW +: BW];
        if (lane_q[i].size() > 0 && lane_q[i][0].cyc == cyc) begin
          exp_t e;
          e = lane_q[i].pop_front();
          check($sformatf("lane%0d_a", i), 64'(ga), 64'(e.a));
          check($sformatf("lane%0d_b", i), 64'(gb), 64'(e.b));
        end else begin
          check($sformatf("lane%0d_idle", i), 64'({ga, gb}), 64'd0);
        end
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check("done_pulse", 64'(done), 64'd1);
      end else begin
        check("done_idle", 64'(done), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start = 1'b1;
    k_len = CW'(k);
    if (k == 0) done_q.push_back(cyc + 1);
    step();
    start = 1'b0;
    k_len = CW'(5);
    m_left = k;
  endtask

  // One cycle of beat stimulus; acceptance is predicted from the bench model.
  task automatic beat(input bit v, input logic [BW*N-1:0] a, input logic [BW*N-1:0] b,
                      input bit st = 1'b0);
    in_valid = v;
    a_vec    = a;
    b_vec    = b;
    start    = st;
    k_len    = st ? CW'(7) : k_len;
    if (v && m_left > 0) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        e.cyc = cyc + 1 + i;
        e.a   = a[i*BW +: BW];
        e.b   = b[i*BW +: BW];
        lane_q[i].push_back(e);
      end
      m_left--;
      if (m_left == 0) done_q.push_back(cyc + N);
    end
    step();
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    start    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, '0);
  endtask

  function automatic logic [BW*N-1:0] pack(input int base);
    logic [BW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_h", 64'(horizontal_input), 64'd0);
    check("rst_v", 64'(vertical_input), 64'd0);
    step();
    rst = 1'b1;
    idle(2);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // k_len=1, lane i carries A=i+1, B=i+5
    do_start(1);
    check("k1_in_ready", 64'(in_ready), 64'd1);
    beat(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5});
    check("k1_ready_drop", 64'(in_ready), 64'd0);
    idle(N + 2);

    // k_len=3 back-to-back; busy spans 3 feed + 3 drain cycles
    busy_cycles = 0;
    do_start(3);
    beat(1'b1, pack(16'h10), pack(16'h110));
    beat(1'b1, pack(16'h20), pack(16'h120));
    beat(1'b1, pack(16'h30), pack(16'h130));
    idle(N + 2);
    check("k3_busy_cycles", 64'(busy_cycles), 64'd6);

    // k_len=2 with in_valid 1,0,1 then a surplus valid beat that must be refused
    do_start(2);
    beat(1'b1, pack(16'h40), pack(16'h140));
    check("k2_ready_mid", 64'(in_ready), 64'd1);
    beat(1'b0, pack(16'hdead), pack(16'hbeef));
    beat(1'b1, pack(16'h50), pack(16'h150));
    check("k2_ready_drop", 64'(in_ready), 64'd0);
    beat(1'b1, pack(16'h60), pack(16'h160));
    idle(N + 2);

    // k_len=0: done next cycle, in_ready never rises
    do_start(0);
    check("k0_ready", 64'(in_ready), 64'd0);
    idle(1);
    check("k0_ready_after", 64'(in_ready), 64'd0);
    idle(2);

    // Second start during FEED with k_len=7 must not reload the count
    do_start(2);
    beat(1'b1, pack(16'h70), pack(16'h170), 1'b1);
    beat(1'b1, pack(16'h80), pack(16'h180));
    check("restart_ignored", 64'(in_ready), 64'd0);
    beat(1'b1, pack(16'h90), pack(16'h190));
    idle(N + 2);

    // Reset mid-FEED after one of four beats
    do_start(4);
    beat(1'b1, pack(16'ha0), pack(16'h1a0));
    check("pre_rst_lane0", 64'(horizontal_input[BW-1:0]), 64'(16'ha0));
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    done_q.delete();
    m_left = 0;
    #1;
    check("mid_rst_h", 64'(horizontal_input), 64'd0);
    check("mid_rst_v", 64'(vertical_input), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b1;
    idle(2);

    // Full tile after reset
    do_start(2);
    beat(1'b1, pack(16'hb0), pack(16'h1b0));
    beat(1'b1, pack(16'hc0), pack(16'h1c0));
    idle(N + 3);

    check("queues_drained",
          64'(lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size() + done_q.size()),
          64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
